// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and helpers used by the ALU and its command queue.
package alu_pkg;

  localparam int unsigned OpWidth = 2;

  // Encoding 2'h3 is reserved and handled as a nop by consumers.
  typedef enum logic [OpWidth-1:0] {
    OpNop = 2'h0,
    OpAdd = 2'h1,
    OpSub = 2'h2
  } operation_t;

  // True for opcodes that do real work in the ALU.
  function automatic logic op_is_exec(input logic [OpWidth-1:0] op);
    return (op == OpAdd) || (op == OpSub);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push is ignored when full, pop when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullLevel = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_q == FullLevel);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Entry storage; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        level_q <= level_q + 1'b1;
      end else if (do_pop && !do_push) begin
        level_q <= level_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_cmd_queue.sv
// Command buffer in front of the 2-stage ALU: drops nops, queues add/sub, issues via a register.
module alu_cmd_queue
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [OpWidth-1:0]       cmd_op,
  input  logic [WIDTH-1:0]         cmd_a,
  input  logic [WIDTH-1:0]         cmd_b,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     issue_en,
  output operation_t               alu_op,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic                     alu_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               drop_cnt
);

  localparam int unsigned FW = OpWidth + 2 * WIDTH;

  logic          full;
  logic          empty;
  logic          accept;
  logic          push;
  logic          pop;
  logic [FW-1:0] rdata;
  logic [FW-1:0] wdata;

  // Ready depends only on stored state (and reset), never on cmd_valid or issue_en.
  assign cmd_ready = !full && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign push      = accept && op_is_exec(cmd_op);
  assign pop       = issue_en && !empty;
  assign wdata     = {cmd_op, cmd_a, cmd_b};

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Issue register: loads the head on pop, otherwise drives an all-zero idle command.
  always_ff @(posedge clk) begin
    if (rst || !pop) begin
      alu_valid <= 1'b0;
      alu_op    <= OpNop;
      alu_a     <= '0;
      alu_b     <= '0;
    end else begin
      alu_valid <= 1'b1;
      alu_op    <= operation_t'(rdata[FW-1 -: OpWidth]);
      alu_a     <= rdata[2*WIDTH-1 -: WIDTH];
      alu_b     <= rdata[WIDTH-1:0];
    end
  end

  // Saturating count of accepted commands that were discarded as nops.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (accept && !op_is_exec(cmd_op) && (drop_cnt != 8'hff)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule
